// File: rtl/cv32e40p_apu_dispatcher.sv
// Routes cv32e40p APU requests to NUM_CH accelerator channels and returns results in issue order.
// Optional stall counter enabled by defining CV32E40P_APU_DISPATCH_PERF_EN.
module cv32e40p_apu_dispatcher #(
    parameter int NUM_CH       = 2,
    parameter int DEPTH        = 4,
    parameter int APU_NARGS    = 3,
    parameter int APU_WOP      = 6,
    parameter int APU_NDSFLAGS = 15,
    parameter int APU_NUSFLAGS = 5,
    parameter int CH_SEL_LSB   = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           apu_req_i,
    output logic                           apu_gnt_o,
    input  logic [APU_NARGS*32-1:0]        apu_operands_i,
    input  logic [APU_WOP-1:0]             apu_op_i,
    input  logic [APU_NDSFLAGS-1:0]        apu_flags_i,
    output logic                           apu_rvalid_o,
    output logic [31:0]                    apu_result_o,
    output logic [APU_NUSFLAGS-1:0]        apu_rflags_o,
    output logic [NUM_CH-1:0]              ch_req_o,
    input  logic [NUM_CH-1:0]              ch_gnt_i,
    output logic [APU_NARGS*32-1:0]        ch_operands_o,
    output logic [APU_WOP-1:0]             ch_op_o,
    output logic [APU_NDSFLAGS-1:0]        ch_flags_o,
    input  logic [NUM_CH-1:0]              ch_rvalid_i,
    input  logic [NUM_CH*32-1:0]           ch_result_i,
    input  logic [NUM_CH*APU_NUSFLAGS-1:0] ch_rflags_i,
    output logic                           busy_o,
    output logic                           err_o,
    output logic [31:0]                    stall_cnt_o
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RES_W = 32 + APU_NUSFLAGS;

    logic [CH_W-1:0]  w_sel_raw;
    logic [CH_W-1:0]  w_sel;
    logic             w_full;
    logic             w_req;
    logic [NUM_CH-1:0] w_issue;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic             w_spur;
    logic [CH_W-1:0]  w_head;
    logic             w_head_avail;
    logic [RES_W-1:0] w_head_data;
    logic             w_retire;

    logic [CH_W-1:0]  r_trk_mem [DEPTH];
    logic [PTR_W-1:0] r_trk_wptr;
    logic [PTR_W-1:0] r_trk_rptr;
    logic [CNT_W-1:0] r_cnt;

    logic [RES_W-1:0] r_res_mem  [NUM_CH][DEPTH];
    logic [PTR_W-1:0] r_res_wptr [NUM_CH];
    logic [PTR_W-1:0] r_res_rptr [NUM_CH];
    logic [CNT_W-1:0] r_res_cnt  [NUM_CH];
    logic [CNT_W-1:0] r_outst    [NUM_CH];

    logic                    r_rvalid;
    logic [31:0]             r_result;
    logic [APU_NUSFLAGS-1:0] r_rflags;
    logic                    r_err;

    // Out-of-range channel fields fall back to channel 0.
    assign w_sel_raw = apu_op_i[CH_SEL_LSB +: CH_W];
    assign w_sel     = ({1'b0, w_sel_raw} < (CH_W+1)'(NUM_CH)) ? w_sel_raw : '0;
    assign w_full    = (r_cnt == CNT_W'(DEPTH));
    assign w_req     = apu_req_i && !w_full && !rst_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ch_req_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_req_o[c] = w_req && (w_sel == CH_W'(c));
        end
    end

    assign w_issue   = ch_req_o & ch_gnt_i;
    assign apu_gnt_o = |w_issue;

    assign ch_operands_o = rst_i ? '0 : apu_operands_i;
    assign ch_op_o       = rst_i ? '0 : apu_op_i;
    assign ch_flags_o    = rst_i ? '0 : apu_flags_i;

    always_comb begin
        w_push = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_push[c] = ch_rvalid_i[c] && (r_outst[c] != '0);
        end
    end

    assign w_spur = |(ch_rvalid_i & ~w_push);
    assign w_head = r_trk_mem[r_trk_rptr];

    // A result arriving for the head op goes straight into the output register.
    always_comb begin
        w_head_avail = 1'b0;
        w_head_data  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_head == CH_W'(c)) begin
                w_head_avail = (r_res_cnt[c] != '0) || w_push[c];
                w_head_data  = (r_res_cnt[c] != '0) ? r_res_mem[c][r_res_rptr[c]]
                             : {ch_result_i[32*c +: 32], ch_rflags_i[APU_NUSFLAGS*c +: APU_NUSFLAGS]};
            end
        end
    end

    assign w_retire = (r_cnt != '0) && w_head_avail;

    always_comb begin
        w_pop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_pop[c] = w_retire && (w_head == CH_W'(c));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_i) begin
            r_trk_wptr <= '0;
            r_trk_rptr <= '0;
            r_cnt      <= '0;
            r_rvalid   <= 1'b0;
            r_result   <= '0;
            r_rflags   <= '0;
            r_err      <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_res_wptr[c] <= '0;
                r_res_rptr[c] <= '0;
                r_res_cnt[c]  <= '0;
                r_outst[c]    <= '0;
            end
        end else begin
            if (apu_gnt_o) r_trk_wptr <= r_trk_wptr + PTR_W'(1);
            if (w_retire)  r_trk_rptr <= r_trk_rptr + PTR_W'(1);
            r_cnt <= r_cnt + CNT_W'(apu_gnt_o) - CNT_W'(w_retire);
            for (int c = 0; c < NUM_CH; c++) begin
                r_outst[c]   <= r_outst[c] + CNT_W'(w_issue[c]) - CNT_W'(w_push[c]);
                r_res_cnt[c] <= r_res_cnt[c] + CNT_W'(w_push[c]) - CNT_W'(w_pop[c]);
                if (w_push[c]) r_res_wptr[c] <= r_res_wptr[c] + PTR_W'(1);
                if (w_pop[c])  r_res_rptr[c] <= r_res_rptr[c] + PTR_W'(1);
            end
            r_rvalid <= w_retire;
            if (w_retire) {r_result, r_rflags} <= w_head_data;
            if (w_spur)   r_err <= 1'b1;
        end
    end

    // NOTE: storage arrays are not reset; the pointers and counters alone define validity.
    always_ff @(posedge clk_i) begin
        if (apu_gnt_o) r_trk_mem[r_trk_wptr] <= w_sel;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_push[c]) begin
                r_res_mem[c][r_res_wptr[c]] <=
                    {ch_result_i[32*c +: 32], ch_rflags_i[APU_NUSFLAGS*c +: APU_NUSFLAGS]};
            end
        end
    end

    assign apu_rvalid_o = r_rvalid;
    assign apu_result_o = r_result;
    assign apu_rflags_o = r_rflags;
    assign busy_o       = (r_cnt != '0) || r_rvalid;
    assign err_o        = r_err;

`ifdef CV32E40P_APU_DISPATCH_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (apu_req_i && !apu_gnt_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_dispatcher.sv
// Self-checking bench for cv32e40p_apu_dispatcher: issue-logic vector table, in-order result scoreboard
// and hand-written sequences for full, spurious-result, stall-counter and reset corner cases.
module tb_cv32e40p_apu_dispatcher;

    localparam int NUM_CH = 3;
    localparam int DEPTH  = 4;
    localparam int NARGS  = 3;
    localparam int WOP    = 6;
    localparam int NDS    = 15;
    localparam int NUS    = 5;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  apu_req_i;
    logic                  apu_gnt_o;
    logic [NARGS*32-1:0]   apu_operands_i;
    logic [WOP-1:0]        apu_op_i;
    logic [NDS-1:0]        apu_flags_i;
    logic                  apu_rvalid_o;
    logic [31:0]           apu_result_o;
    logic [NUS-1:0]        apu_rflags_o;
    logic [NUM_CH-1:0]     ch_req_o;
    logic [NUM_CH-1:0]     ch_gnt_i;
    logic [NARGS*32-1:0]   ch_operands_o;
    logic [WOP-1:0]        ch_op_o;
    logic [NDS-1:0]        ch_flags_o;
    logic [NUM_CH-1:0]     ch_rvalid_i;
    logic [NUM_CH*32-1:0]  ch_result_i;
    logic [NUM_CH*NUS-1:0] ch_rflags_i;
    logic                  busy_o;
    logic                  err_o;
    logic [31:0]           stall_cnt_o;

    cv32e40p_apu_dispatcher #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .APU_NARGS(NARGS), .APU_WOP(WOP),
        .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS), .CH_SEL_LSB(3)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o),
        .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i), .apu_flags_i(apu_flags_i),
        .apu_rvalid_o(apu_rvalid_o), .apu_result_o(apu_result_o), .apu_rflags_o(apu_rflags_o),
        .ch_req_o(ch_req_o), .ch_gnt_i(ch_gnt_i),
        .ch_operands_o(ch_operands_o), .ch_op_o(ch_op_o), .ch_flags_o(ch_flags_o),
        .ch_rvalid_i(ch_rvalid_i), .ch_result_i(ch_result_i), .ch_rflags_i(ch_rflags_i),
        .busy_o(busy_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]    res;
        logic [NUS-1:0] flg;
    } exp_t;

    typedef struct {
        logic              req;
        logic [1:0]        field;
        logic [NUM_CH-1:0] gnt;
        logic [NUM_CH-1:0] exp_req;
        logic              exp_gnt;
        int                exp_ch;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t ch_q[NUM_CH][$];
    vec_t vecs[9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic record_grant(input int ch, input logic [31:0] res, input logic [NUS-1:0] flg);
        exp_t e;
        e.res = res;
        e.flg = flg;
        sb.push_back(e);
        ch_q[ch].push_back(e);
    endtask

    task automatic drive_resp(input logic [NUM_CH-1:0] mask);
        exp_t e;
        ch_rvalid_i = mask;
        ch_result_i = '0;
        ch_rflags_i = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mask[c] && ch_q[c].size() != 0) begin
                e = ch_q[c].pop_front();
                ch_result_i[32*c +: 32]  = e.res;
                ch_rflags_i[NUS*c +: NUS] = e.flg;
            end
        end
    endtask

    task automatic respond(input logic [NUM_CH-1:0] mask);
        drive_resp(mask);
        @(negedge clk_i);
        drive_resp('0);
    endtask

    task automatic set_req(input logic req, input logic [1:0] field, input logic [NUM_CH-1:0] gnt);
        apu_req_i      = req;
        apu_op_i       = {1'b0, field, 3'b101};
        ch_gnt_i       = gnt;
        apu_operands_i = {$urandom, $urandom, $urandom};
        apu_flags_i    = NDS'($urandom);
    endtask

    task automatic wait_sb_empty(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge clk_i);
        check("sb_drain", 128'(sb.size()), 128'd0);
    endtask

    // Scoreboard monitor: every result pulse must match the oldest outstanding expectation.
    always @(posedge clk_i) begin
        #1;
        if (apu_rvalid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", 128'(apu_result_o), 128'(e.res));
                check("sb_rflags", 128'(apu_rflags_o), 128'(e.flg));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          req  field  gnt      exp_req  exp_gnt exp_ch
        vecs[0] = '{1'b0, 2'd1, 3'b111, 3'b000, 1'b0, 0};
        vecs[1] = '{1'b1, 2'd1, 3'b000, 3'b010, 1'b0, 1};
        vecs[2] = '{1'b1, 2'd0, 3'b001, 3'b001, 1'b1, 0};
        vecs[3] = '{1'b1, 2'd2, 3'b011, 3'b100, 1'b0, 2};
        vecs[4] = '{1'b1, 2'd3, 3'b001, 3'b001, 1'b1, 0};
        vecs[5] = '{1'b1, 2'd2, 3'b100, 3'b100, 1'b1, 2};
        vecs[6] = '{1'b1, 2'd1, 3'b010, 3'b010, 1'b1, 1};
        vecs[7] = '{1'b1, 2'd0, 3'b111, 3'b000, 1'b0, 0};
        vecs[8] = '{1'b0, 2'd0, 3'b111, 3'b000, 1'b0, 0};

        rst_i = 1'b1;
        set_req(1'b0, 2'd0, '0);
        drive_resp('0);
        repeat (3) @(negedge clk_i);
        check("rst_rvalid", 128'(apu_rvalid_o), 128'd0);
        check("rst_busy",   128'(busy_o),       128'd0);
        check("rst_err",    128'(err_o),        128'd0);
        check("rst_stall",  128'(stall_cnt_o),  128'd0);
        check("rst_result", 128'(apu_result_o), 128'd0);
        rst_i = 1'b0;

        // Single op to ch1, result two cycles after grant.
        @(negedge clk_i);
        set_req(1'b1, 2'd1, 3'b010);
        #1;
        check("single_req", 128'(ch_req_o),  128'(3'b010));
        check("single_gnt", 128'(apu_gnt_o), 128'd1);
        check("single_operands", 128'(ch_operands_o), 128'(apu_operands_i));
        check("single_op", 128'(ch_op_o), 128'(apu_op_i));
        record_grant(1, 32'hDEADBEEF, 5'h3);
        @(negedge clk_i);
        set_req(1'b0, 2'd0, '0);
        #1 check("single_busy", 128'(busy_o), 128'd1);
        @(negedge clk_i);
        drive_resp(3'b010);
        #1 check("single_no_early_rvalid", 128'(apu_rvalid_o), 128'd0);
        @(negedge clk_i);
        drive_resp('0);
        #1;
        check("single_rvalid", 128'(apu_rvalid_o), 128'd1);
        check("single_result", 128'(apu_result_o), 128'(32'hDEADBEEF));
        check("single_rflags", 128'(apu_rflags_o), 128'(5'h3));
        @(negedge clk_i);
        #1;
        check("single_pulse_end", 128'(apu_rvalid_o), 128'd0);
        check("single_hold",      128'(apu_result_o), 128'(32'hDEADBEEF));
        check("single_idle",      128'(busy_o),       128'd0);

        // Out-of-order completion: A to ch0, B to ch1, ch1 answers first.
        @(negedge clk_i);
        set_req(1'b1, 2'd0, 3'b001);
        record_grant(0, 32'h1, 5'h1);
        @(negedge clk_i);
        set_req(1'b1, 2'd1, 3'b010);
        record_grant(1, 32'h2, 5'h2);
        @(negedge clk_i);
        set_req(1'b0, 2'd0, '0);
        respond(3'b010);
        #1 check("ooo_held_back", 128'(apu_rvalid_o), 128'd0);
        respond(3'b001);
        wait_sb_empty(20);

        // Issue-logic vector table; granted ops land in the scoreboard.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            set_req(vecs[i].req, vecs[i].field, vecs[i].gnt);
            #1;
            check($sformatf("vec%0d_req", i), 128'(ch_req_o),  128'(vecs[i].exp_req));
            check($sformatf("vec%0d_gnt", i), 128'(apu_gnt_o), 128'(vecs[i].exp_gnt));
            if (vecs[i].exp_gnt) record_grant(vecs[i].exp_ch, 32'hA000_0000 + 32'(i), NUS'(i));
        end
        @(negedge clk_i);
        set_req(1'b0, 2'd0, '0);
        #1 check("table_busy", 128'(busy_o), 128'd1);
        respond(3'b110);
        respond(3'b001);
        respond(3'b001);
        wait_sb_empty(20);

        // Full: four ops to ch0 block the fifth, even in the retire cycle.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            set_req(1'b1, 2'd0, 3'b001);
            #1 check($sformatf("fill%0d_gnt", k), 128'(apu_gnt_o), 128'd1);
            record_grant(0, 32'hB000_0000 + 32'(k), NUS'(k));
        end
        @(negedge clk_i);
        #1;
        check("full_block_req", 128'(ch_req_o),  128'd0);
        check("full_block_gnt", 128'(apu_gnt_o), 128'd0);
        @(negedge clk_i);
        drive_resp(3'b001);
        #1 check("full_retire_cycle_req", 128'(ch_req_o), 128'd0);
        @(negedge clk_i);
        drive_resp(3'b001);
        #1;
        check("after_retire_req", 128'(ch_req_o),  128'(3'b001));
        check("after_retire_gnt", 128'(apu_gnt_o), 128'd1);
        record_grant(0, 32'hB000_0004, 5'h4);
        @(negedge clk_i);
        set_req(1'b0, 2'd0, '0);
        drive_resp(3'b001);
        @(negedge clk_i);
        drive_resp(3'b001);
        @(negedge clk_i);
        drive_resp(3'b001);
        @(negedge clk_i);
        drive_resp('0);
        wait_sb_empty(20);
        @(negedge clk_i);
        #1;
        check("full_no_err", 128'(err_o),  128'd0);
        check("full_idle",   128'(busy_o), 128'd0);

        // Stall counter over a clean reset.
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            set_req(1'b1, 2'd1, 3'b000);
        end
        @(negedge clk_i);
        set_req(1'b0, 2'd0, '0);
        #1;
`ifdef CV32E40P_APU_DISPATCH_PERF_EN
        check("stall_cnt", 128'(stall_cnt_o), 128'd5);
`else
        check("stall_cnt", 128'(stall_cnt_o), 128'd0);
`endif

        // Reset with an op in flight on ch1 and a stalled request pending.
        @(negedge clk_i);
        set_req(1'b1, 2'd1, 3'b010);
        record_grant(1, 32'hC0FFEE00, 5'h7);
        @(negedge clk_i);
        set_req(1'b1, 2'd1, 3'b000);
        #2 rst_i = 1'b1;
        #1;
        sb.delete();
        check("midrst_req",      128'(ch_req_o),      128'd0);
        check("midrst_gnt",      128'(apu_gnt_o),     128'd0);
        check("midrst_rvalid",   128'(apu_rvalid_o),  128'd0);
        check("midrst_busy",     128'(busy_o),        128'd0);
        check("midrst_err",      128'(err_o),         128'd0);
        check("midrst_stall",    128'(stall_cnt_o),   128'd0);
        check("midrst_result",   128'(apu_result_o),  128'd0);
        check("midrst_operands", 128'(ch_operands_o), 128'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        set_req(1'b0, 2'd0, '0);

        // Late ch1 result after reset is spurious.
        @(negedge clk_i);
        respond(3'b010);
        #1;
        check("spur_err",    128'(err_o),        128'd1);
        check("spur_rvalid", 128'(apu_rvalid_o), 128'd0);
        check("spur_busy",   128'(busy_o),       128'd0);
        repeat (3) @(negedge clk_i);
        check("spur_sticky", 128'(err_o), 128'd1);
        check("end_sb_empty", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
